nibble_splitter: RTL

//   Reverse of the ALU nibble-concatenation path. Accepts one IN_W-bit word per

---
 rtl/nibble_splitter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/nibble_splitter.sv
// rtl/nibble_splitter.sv - splits one wide word into N narrow slices over valid/ready
module nibble_splitter #(
   parameter int IN_W      = 8,
   parameter int OUT_W     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [IN_W-1:0]  data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [OUT_W-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic             first_o,
   output logic             last_o
);

   // Number of slices per word and the width of the slice counter.
   localparam int N     = IN_W / OUT_W;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [IN_W-1:0]  r_wreg;
   logic [IDX_W-1:0] r_idx;
   logic [OUT_W-1:0] w_slices [N];
   logic [OUT_W-1:0] w_cur_slice;
   logic             w_is_last;
   logic             w_in_hs;
   logic             w_out_hs;

   // Slice k of the held word, ordered so that k=0 is always emitted first.
   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_slice
         if (MSB_FIRST) begin : g_msb
            assign w_slices[g] = r_wreg[IN_W-1-g*OUT_W -: OUT_W];
         end else begin : g_lsb
            assign w_slices[g] = r_wreg[g*OUT_W +: OUT_W];
         end
      end
   endgenerate

   assign w_cur_slice = w_slices[r_idx];
   assign w_is_last   = (r_idx == LAST_IDX);
   assign w_in_hs     = valid_i & ready_o;
   assign w_out_hs    = valid_o & ready_i;

   // State register; reset drops any word in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: leave SEND only when the last slice goes out with no follow-on word.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (valid_i) begin
               w_next_state = S_SEND;
            end
         end
         S_SEND: begin
            if (w_out_hs && w_is_last && !valid_i) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Word register and slice index; a new word can be loaded back-to-back on the last slice.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wreg <= '0;
         r_idx  <= '0;
      end else if (w_in_hs) begin
         r_wreg <= data_i;
         r_idx  <= '0;
      end else if (w_out_hs && !w_is_last) begin
         r_idx  <= r_idx + IDX_W'(1);
      end
   end

   // Outputs decoded from state; ready_o passes ready_i through only on the last slice.
   always_comb begin
      valid_o = 1'b0;
      data_o  = '0;
      first_o = 1'b0;
      last_o  = 1'b0;
      ready_o = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready_o = 1'b1;
         end
         S_SEND: begin
            valid_o = 1'b1;
            data_o  = w_cur_slice;
            first_o = (r_idx == '0);
            last_o  = w_is_last;
            ready_o = w_is_last & ready_i;
         end
         default: begin
            ready_o = 1'b0;
         end
      endcase
   end

endmodule
